fv_core_ex_rf_tracker: RTL and testbench
========================================

FV_CORE_EX_RF_TRACKER -- requirements
Module: fv_core_ex_rf_tracker

Interface
REQ-001 SHALL: parameter NUM_REGS, 32, register-file entries, even, power of two.
REQ-002 SHALL: parameter NUM_WR_PORTS, 2, write/lock ports, 1..8.
REQ-003 SHALL: parameter ADDR_W, $clog2(NUM_REGS), register address width.
REQ-004 SHALL: parameter CNT_W, 8, width of per-register and total counters.
REQ-005 SHALL: parameter PAIR_MODE, 0, dup mapping: 0 = dup(r)=r+NUM_REGS/2, 1 = dup(r)=r^1.
REQ-006 SHALL: parameter EXCL_MASK, NUM_REGS bits, bit0 and bit dup(0) set, registers excluded from total counts.
REQ-007 SHALL: one clock; reset is asynchronous and active-low; ports clk and reset_.
REQ-008 SHALL: clk  in  1  clock; reset_  in  1  async active-low reset.
REQ-009 SHALL: wr_en  in  NUM_WR_PORTS  per-port write valid; wr_rd  in  NUM_WR_PORTS*ADDR_W  write destinations.
REQ-010 SHALL: lock, unlock  in  NUM_WR_PORTS each  lock events; lock_num  in  NUM_WR_PORTS*ADDR_W  lock targets.
REQ-011 SHALL: dup_enable, dup_done, sync_ready, clear  in  1 each  control.
REQ-012 SHALL: ready  out  1; pair_ready  out  NUM_REGS/2; total_orig, total_dup  out  CNT_W each.
REQ-013 SHALL: any_locked, sat_err, lock_err  out  1 each.

Function
REQ-014 SHALL: orig write = wr_en[p] && wr_rd[p] is an original register && not excluded by EXCL_MASK; dup write likewise for dup registers.
REQ-015 SHALL: total_orig/total_dup increase by the per-cycle counts of orig/dup writes; a write in cycle n is visible at cycle n+1.
REQ-016 SHALL: per-register counter cnt[r] increases by the number of ports writing r in that cycle, regardless of EXCL_MASK.
REQ-017 SHALL: all counters saturate at 2^CNT_W-1, never wrap; any saturation event sets sticky sat_err.
REQ-018 SHALL: lock bits update in port order 1..NUM_WR_PORTS, lock before unlock within a port; the last applicable event wins; redundant lock/unlock leaves the bit unchanged.
REQ-019 SHALL: any_locked = OR of all lock bits (registered state).
REQ-020 SHALL: ready = dup_enable && !sat_err && ((total_orig == total_dup) || dup_done).
REQ-021 SHALL: pair_ready[k] = dup_done || (!lock[orig(k)] && !lock[dup(k)] && cnt[orig(k)] == cnt[dup(k)] && !sat_err).
REQ-022 SHALL: sync_ready asserted while any_locked sets sticky lock_err next cycle.
REQ-023 SHALL: clear synchronously zeroes counters, lock bits, sat_err, and lock_err; clear overrides same-cycle writes/locks.
REQ-024 SHALL: writes/locks to addresses >= NUM_REGS are ignored.

Reset
REQ-025 SHALL: reset_ low asynchronously zeroes all counters, lock bits, sat_err, and lock_err.
REQ-026 SHALL: outputs after reset: total_orig=0, total_dup=0, any_locked=0, sat_err=0, lock_err=0, ready=dup_enable, pair_ready=all ones.
REQ-027 SHALL: reset mid-operation discards in-flight cycle updates; counting resumes on the first clk edge after reset_ deasserts.

Structure
REQ-028 SHALL: package fv_core_ex_rf_pkg holds dup/orig mapping functions (PAIR_MODE-aware), is_dup_reg, and default parameter constants.
REQ-029 SHALL: sub-module fv_core_ex_rf_portcount computes the per-cycle saturating add of port hits, instantiated once per counter class.
REQ-030 SHALL: no assertions inside RTL except under the debug define; sticky flags replace them.

Verification
REQ-031 SHALL: P=2, mode 0: wr r3 port1 and r19 port2 same cycle -> next cycle total_orig=1, total_dup=1, ready=1, pair_ready[3]=1.
REQ-032 SHALL: wr r5 only -> total_orig=1, ready=0, pair_ready[5]=0; then wr r21 -> both 1.
REQ-033 SHALL: CNT_W=3, 8 writes to r2 -> cnt[r2]=7, sat_err=1, ready=0; dup_done=1 -> pair_ready all 1, ready still 0.
REQ-034 SHALL: lock r4 port1, unlock r4 port2 same cycle -> lock bit 0; lock r4 then sync_ready -> lock_err=1 next cycle.
REQ-035 SHALL: mode 1, writes r0 and r1 -> totals unchanged (r0/r1 excluded), cnt[r1]=1, pair_ready[0]=0.
REQ-036 SHALL: reset_ low mid-count, or clear with simultaneous writes -> all counters 0 next observation, sticky flags 0.

Source files
------------

// File: rtl/fv_core_ex_rf_pkg.sv
// Shared defaults and orig/dup register mapping helpers for the EX register-file tracker.
// PAIR_MODE 0 pairs r with r+N/2; PAIR_MODE 1 pairs r with r^1.
package fv_core_ex_rf_pkg;

  localparam int unsigned DEF_NUM_REGS     = 32;
  localparam int unsigned DEF_NUM_WR_PORTS = 2;
  localparam int unsigned DEF_CNT_W        = 8;
  localparam int unsigned DEF_PAIR_MODE    = 0;

  function automatic int unsigned dup_of(input int unsigned r, input int unsigned n, input bit mode);
    return mode ? (r ^ 32'd1) : (r + n / 2);
  endfunction

  function automatic int unsigned orig_of(input int unsigned k, input bit mode);
    return mode ? (2 * k) : k;
  endfunction

  function automatic bit is_dup_reg(input int unsigned r, input int unsigned n, input bit mode);
    return mode ? r[0] : (r >= n / 2);
  endfunction

endpackage

// File: rtl/fv_core_ex_rf_portcount.sv
// Saturating accumulate of per-port hit bits onto a counter; flags attempts to exceed full scale.
module fv_core_ex_rf_portcount #(
  parameter int unsigned NUM_WR_PORTS = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic [NUM_WR_PORTS-1:0] hits,
  input  logic [CNT_W-1:0]        cur,
  output logic [CNT_W-1:0]        nxt,
  output logic                    sat
);

  localparam int unsigned SUM_W = CNT_W + 4;

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = SUM_W'(cur);
    for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
      sum = sum + SUM_W'(hits[p]);
    end
    sat = (sum > SUM_W'({CNT_W{1'b1}}));
    nxt = sat ? '1 : sum[CNT_W-1:0];
  end

endmodule

// File: rtl/fv_core_ex_rf_tracker.sv
// Tracks writes to original/duplicate register pairs, per-register lock state, and
// derives pair/overall readiness with sticky saturation and lock-violation flags.
module fv_core_ex_rf_tracker
  import fv_core_ex_rf_pkg::*;
#(
  parameter int unsigned         NUM_REGS     = DEF_NUM_REGS,
  parameter int unsigned         NUM_WR_PORTS = DEF_NUM_WR_PORTS,
  parameter int unsigned         ADDR_W       = $clog2(NUM_REGS),
  parameter int unsigned         CNT_W        = DEF_CNT_W,
  parameter int unsigned         PAIR_MODE    = DEF_PAIR_MODE,
  parameter logic [NUM_REGS-1:0] EXCL_MASK    = NUM_REGS'(1) |
                                                (NUM_REGS'(1) << dup_of(0, NUM_REGS, (PAIR_MODE != 0)))
) (
  input  logic                           clk,
  input  logic                           reset_,
  input  logic [NUM_WR_PORTS-1:0]        wr_en,
  input  logic [NUM_WR_PORTS*ADDR_W-1:0] wr_rd,
  input  logic [NUM_WR_PORTS-1:0]        lock,
  input  logic [NUM_WR_PORTS-1:0]        unlock,
  input  logic [NUM_WR_PORTS*ADDR_W-1:0] lock_num,
  input  logic                           dup_enable,
  input  logic                           dup_done,
  input  logic                           sync_ready,
  input  logic                           clear,
  output logic                           ready,
  output logic [NUM_REGS/2-1:0]          pair_ready,
  output logic [CNT_W-1:0]               total_orig,
  output logic [CNT_W-1:0]               total_dup,
  output logic                           any_locked,
  output logic                           sat_err,
  output logic                           lock_err
);

  localparam bit MODE = (PAIR_MODE != 0);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(NUM_REGS);
  endfunction

  logic [CNT_W-1:0]        cnt_q     [NUM_REGS];
  logic [CNT_W-1:0]        cnt_nxt   [NUM_REGS];
  logic [NUM_WR_PORTS-1:0] reg_hits  [NUM_REGS];
  logic [NUM_REGS-1:0]     reg_sat;
  logic [NUM_REGS-1:0]     lock_q, lock_nxt;
  logic [NUM_WR_PORTS-1:0] orig_hits, dup_hits;
  logic [CNT_W-1:0]        orig_nxt, dup_nxt;
  logic                    orig_sat, dup_sat;
  logic [ADDR_W-1:0]       wr_addr, lk_addr;

  always_comb begin
    orig_hits = '0;
    dup_hits  = '0;
    wr_addr   = '0;
    for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
      wr_addr = wr_rd[p*ADDR_W +: ADDR_W];
      if (wr_en[p] && addr_ok(wr_addr) && !EXCL_MASK[wr_addr]) begin
        if (is_dup_reg(32'(wr_addr), NUM_REGS, MODE)) dup_hits[p]  = 1'b1;
        else                                          orig_hits[p] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
        reg_hits[r][p] = wr_en[p] && (wr_rd[p*ADDR_W +: ADDR_W] == ADDR_W'(r));
      end
    end
  end

  // Ports are applied in ascending order so a later port's event overrides an earlier one.
  always_comb begin
    lock_nxt = lock_q;
    lk_addr  = '0;
    for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
      lk_addr = lock_num[p*ADDR_W +: ADDR_W];
      if (addr_ok(lk_addr)) begin
        if (lock[p])   lock_nxt[lk_addr] = 1'b1;
        if (unlock[p]) lock_nxt[lk_addr] = 1'b0;
      end
    end
  end

  fv_core_ex_rf_portcount #(.NUM_WR_PORTS(NUM_WR_PORTS), .CNT_W(CNT_W)) u_orig_cnt (
    .hits(orig_hits), .cur(total_orig), .nxt(orig_nxt), .sat(orig_sat)
  );

  fv_core_ex_rf_portcount #(.NUM_WR_PORTS(NUM_WR_PORTS), .CNT_W(CNT_W)) u_dup_cnt (
    .hits(dup_hits), .cur(total_dup), .nxt(dup_nxt), .sat(dup_sat)
  );

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    fv_core_ex_rf_portcount #(.NUM_WR_PORTS(NUM_WR_PORTS), .CNT_W(CNT_W)) u_reg_cnt (
      .hits(reg_hits[r]), .cur(cnt_q[r]), .nxt(cnt_nxt[r]), .sat(reg_sat[r])
    );
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt_q      <= '{default: '0};
      lock_q     <= '0;
      total_orig <= '0;
      total_dup  <= '0;
      sat_err    <= 1'b0;
      lock_err   <= 1'b0;
    end else if (clear) begin
      cnt_q      <= '{default: '0};
      lock_q     <= '0;
      total_orig <= '0;
      total_dup  <= '0;
      sat_err    <= 1'b0;
      lock_err   <= 1'b0;
    end else begin
      cnt_q      <= cnt_nxt;
      lock_q     <= lock_nxt;
      total_orig <= orig_nxt;
      total_dup  <= dup_nxt;
      sat_err    <= sat_err | orig_sat | dup_sat | (|reg_sat);
      lock_err   <= lock_err | (sync_ready && (|lock_q));
    end
  end

  assign any_locked = |lock_q;
  assign ready      = dup_enable && !sat_err && ((total_orig == total_dup) || dup_done);

  for (genvar k = 0; k < NUM_REGS / 2; k++) begin : g_pair
    localparam int unsigned O = orig_of(k, MODE);
    localparam int unsigned D = dup_of(O, NUM_REGS, MODE);
    assign pair_ready[k] = dup_done ||
                           (!lock_q[O] && !lock_q[D] && (cnt_q[O] == cnt_q[D]) && !sat_err);
  end

endmodule

// File: tb/tb_fv_core_ex_rf_tracker.sv
// Three tracker variants (default, 3-bit counters, xor pairing) driven with shared stimulus
// and compared every cycle against an array-based reference model.
module tb_fv_core_ex_rf_tracker;

  localparam int NR = 32;
  localparam int P  = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk = ~clk;

  logic [P-1:0]    wr_en, lock, unlock;
  logic [P*AW-1:0] wr_rd, lock_num;
  logic            dup_enable, dup_done, sync_ready, clear;

  logic rdy0, rdy1, rdy2, al0, al1, al2, se0, se1, se2, le0, le1, le2;
  logic [15:0] pr0, pr1, pr2;
  logic [7:0]  to0, td0, to2, td2;
  logic [2:0]  to1, td1;

  fv_core_ex_rf_tracker u_dut0 (
    .clk(clk), .reset_(reset_), .wr_en(wr_en), .wr_rd(wr_rd), .lock(lock), .unlock(unlock),
    .lock_num(lock_num), .dup_enable(dup_enable), .dup_done(dup_done), .sync_ready(sync_ready),
    .clear(clear), .ready(rdy0), .pair_ready(pr0), .total_orig(to0), .total_dup(td0),
    .any_locked(al0), .sat_err(se0), .lock_err(le0)
  );

  fv_core_ex_rf_tracker #(.CNT_W(3)) u_dut1 (
    .clk(clk), .reset_(reset_), .wr_en(wr_en), .wr_rd(wr_rd), .lock(lock), .unlock(unlock),
    .lock_num(lock_num), .dup_enable(dup_enable), .dup_done(dup_done), .sync_ready(sync_ready),
    .clear(clear), .ready(rdy1), .pair_ready(pr1), .total_orig(to1), .total_dup(td1),
    .any_locked(al1), .sat_err(se1), .lock_err(le1)
  );

  fv_core_ex_rf_tracker #(.PAIR_MODE(1)) u_dut2 (
    .clk(clk), .reset_(reset_), .wr_en(wr_en), .wr_rd(wr_rd), .lock(lock), .unlock(unlock),
    .lock_num(lock_num), .dup_enable(dup_enable), .dup_done(dup_done), .sync_ready(sync_ready),
    .clear(clear), .ready(rdy2), .pair_ready(pr2), .total_orig(to2), .total_dup(td2),
    .any_locked(al2), .sat_err(se2), .lock_err(le2)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state, one slot per DUT variant.
  int mcnt [3][NR];
  bit mlk  [3][NR];
  int mto  [3];
  int mtd  [3];
  bit msat [3];
  bit mlerr[3];
  int mode_of[3] = '{0, 0, 1};
  int max_of [3] = '{255, 7, 255};

  function automatic int dupr(input int r, input int m);
    return (m != 0) ? (r ^ 1) : (r + NR / 2);
  endfunction

  function automatic bit isdup(input int r, input int m);
    return (m != 0) ? (r % 2 == 1) : (r >= NR / 2);
  endfunction

  function automatic bit excl(input int r, input int m);
    return (r == 0) || (r == dupr(0, m));
  endfunction

  task automatic sadd(input int v, input int a, input int mx, output int res, output bit ov);
    res = v + a;
    ov  = res > mx;
    if (ov) res = mx;
  endtask

  task automatic model_zero(input int i);
    for (int r = 0; r < NR; r++) begin
      mcnt[i][r] = 0;
      mlk[i][r]  = 1'b0;
    end
    mto[i] = 0; mtd[i] = 0; msat[i] = 1'b0; mlerr[i] = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) model_zero(i);
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        model_zero(i);
      end else begin
        int add[NR];
        int ao, ad, r, n, res;
        bit anyl, ov;
        ao = 0; ad = 0; anyl = 1'b0;
        for (int q = 0; q < NR; q++) begin
          add[q] = 0;
          anyl |= mlk[i][q];
        end
        for (int p = 0; p < P; p++) begin
          if (wr_en[p]) begin
            r = int'(wr_rd[p*AW +: AW]);
            add[r]++;
            if (!excl(r, mode_of[i])) begin
              if (isdup(r, mode_of[i])) ad++;
              else ao++;
            end
          end
        end
        for (int q = 0; q < NR; q++) begin
          sadd(mcnt[i][q], add[q], max_of[i], res, ov);
          mcnt[i][q] = res;
          msat[i] |= ov;
        end
        sadd(mto[i], ao, max_of[i], res, ov); mto[i] = res; msat[i] |= ov;
        sadd(mtd[i], ad, max_of[i], res, ov); mtd[i] = res; msat[i] |= ov;
        for (int p = 0; p < P; p++) begin
          n = int'(lock_num[p*AW +: AW]);
          if (lock[p])   mlk[i][n] = 1'b1;
          if (unlock[p]) mlk[i][n] = 1'b0;
        end
        mlerr[i] |= sync_ready && anyl;
      end
    end
  endtask

  task automatic check_inst(input int i, input logic rdy, input logic [15:0] prv,
                            input logic [7:0] tov, input logic [7:0] tdv,
                            input logic alv, input logic sev, input logic lev);
    bit anyl, erdy;
    logic [15:0] epr;
    int o, d, m;
    m = mode_of[i];
    anyl = 1'b0;
    for (int r = 0; r < NR; r++) anyl |= mlk[i][r];
    for (int k = 0; k < NR / 2; k++) begin
      o = (m != 0) ? 2 * k : k;
      d = dupr(o, m);
      epr[k] = dup_done || (!mlk[i][o] && !mlk[i][d] && mcnt[i][o] == mcnt[i][d] && !msat[i]);
    end
    erdy = dup_enable && !msat[i] && ((mto[i] == mtd[i]) || dup_done);
    check($sformatf("i%0d_total_orig", i), 32'(tov), 32'(mto[i]));
    check($sformatf("i%0d_total_dup", i),  32'(tdv), 32'(mtd[i]));
    check($sformatf("i%0d_any_locked", i), 32'(alv), 32'(anyl));
    check($sformatf("i%0d_sat_err", i),    32'(sev), 32'(msat[i]));
    check($sformatf("i%0d_lock_err", i),   32'(lev), 32'(mlerr[i]));
    check($sformatf("i%0d_ready", i),      32'(rdy), 32'(erdy));
    check($sformatf("i%0d_pair_ready", i), 32'(prv), 32'(epr));
  endtask

  task automatic check_all();
    check_inst(0, rdy0, pr0, to0, td0, al0, se0, le0);
    check_inst(1, rdy1, pr1, {5'b0, to1}, {5'b0, td1}, al1, se1, le1);
    check_inst(2, rdy2, pr2, to2, td2, al2, se2, le2);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    wr_en = '0; wr_rd = '0; lock = '0; unlock = '0; lock_num = '0;
    sync_ready = 1'b0; clear = 1'b0; dup_done = 1'b0;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic wr1(input int a);
    idle();
    wr_en = 2'b01;
    wr_rd = {5'd0, 5'(a)};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    dup_enable = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    check("rst_pair_ready_ones", 32'(pr0), 32'hFFFF);
    check("rst_ready_dis", 32'(rdy0), 32'd0);
    dup_enable = 1'b1;
    #1 check("rst_ready_en", 32'(rdy0), 32'd1);
    @(negedge clk);
    reset_ = 1'b1;

    // Paired write on both ports in one cycle.
    do_clear();
    idle(); wr_en = 2'b11; wr_rd = {5'd19, 5'd3};
    step();
    check("pair_to", 32'(to0), 32'd1);
    check("pair_td", 32'(td0), 32'd1);
    check("pair_ready", 32'(rdy0), 32'd1);
    check("pair_pr3", 32'(pr0[3]), 32'd1);

    // Original first, duplicate later.
    do_clear();
    wr1(5); step();
    check("half_to", 32'(to0), 32'd1);
    check("half_ready", 32'(rdy0), 32'd0);
    check("half_pr5", 32'(pr0[5]), 32'd0);
    wr1(21); step();
    check("full_td", 32'(td0), 32'd1);
    check("full_ready", 32'(rdy0), 32'd1);
    check("full_pr5", 32'(pr0[5]), 32'd1);

    // 3-bit counters: seventh write reaches full scale, eighth overflows.
    do_clear();
    wr1(2);
    repeat (7) step();
    check("sat7_err", 32'(se1), 32'd0);
    check("sat7_to", 32'(to1), 32'd7);
    step();
    check("sat8_err", 32'(se1), 32'd1);
    check("sat8_to", 32'(to1), 32'd7);
    check("sat8_ready", 32'(rdy1), 32'd0);
    idle(); dup_done = 1'b1; step();
    check("sat_done_pr", 32'(pr1), 32'hFFFF);
    check("sat_done_ready", 32'(rdy1), 32'd0);

    // Lock ordering and lock violation.
    do_clear();
    idle(); lock = 2'b01; unlock = 2'b10; lock_num = {5'd4, 5'd4}; step();
    check("lk_cancel", 32'(al0), 32'd0);
    idle(); lock = 2'b10; unlock = 2'b01; lock_num = {5'd4, 5'd4}; step();
    check("lk_last_wins", 32'(al0), 32'd1);
    idle(); unlock = 2'b01; lock_num = {5'd0, 5'd4}; step();
    check("lk_unlock", 32'(al0), 32'd0);
    idle(); lock = 2'b01; lock_num = {5'd0, 5'd4}; step();
    check("lk_set", 32'(al0), 32'd1);
    check("lk_err_pre", 32'(le0), 32'd0);
    idle(); sync_ready = 1'b1; step();
    check("lk_err", 32'(le0), 32'd1);

    // Xor pairing: r0/r1 excluded from totals but still counted per register.
    do_clear();
    wr1(1); step();
    check("x_to", 32'(to2), 32'd0);
    check("x_td", 32'(td2), 32'd0);
    check("x_pr0_lo", 32'(pr2[0]), 32'd0);
    wr1(0); step();
    check("x_pr0_eq", 32'(pr2[0]), 32'd1);
    check("x_to2", 32'(to2), 32'd0);

    // Asynchronous reset mid-count, then counting resumes immediately.
    idle(); wr_en = 2'b11; wr_rd = {5'd20, 5'd7}; lock = 2'b01; lock_num = {5'd0, 5'd9};
    step(); step();
    #2 reset_ = 1'b0;
    model_reset();
    #1;
    check("ar_to", 32'(to0), 32'd0);
    check("ar_lock", 32'(al0), 32'd0);
    @(negedge clk);
    check_all();
    reset_ = 1'b1;
    wr1(3); step();
    check("ar_resume", 32'(to0), 32'd1);

    // Clear overrides same-cycle writes and locks.
    idle(); wr_en = 2'b11; wr_rd = {5'd17, 5'd2}; step();
    clear = 1'b1; wr_en = 2'b11; lock = 2'b11; lock_num = {5'd6, 5'd2}; step();
    check("clr_to", 32'(to0), 32'd0);
    check("clr_lock", 32'(al0), 32'd0);
    check("clr_sat", 32'(se1), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      idle();
      wr_en = 2'($urandom);
      for (int p = 0; p < P; p++) begin
        if ($urandom_range(0, 1) == 0) wr_rd[p*AW +: AW] = 5'($urandom_range(0, 31));
        else wr_rd[p*AW +: AW] = 5'($urandom_range(0, 3)) | (($urandom_range(0, 1) == 1) ? 5'd16 : 5'd0);
        lock[p]   = ($urandom_range(0, 7) == 0);
        unlock[p] = ($urandom_range(0, 3) == 0);
        lock_num[p*AW +: AW] = 5'($urandom_range(0, 31));
      end
      sync_ready = ($urandom_range(0, 15) == 0);
      dup_done   = ($urandom_range(0, 3) == 0);
      dup_enable = ($urandom_range(0, 7) != 0);
      clear      = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
